// File: rtl/tnn_stream_classifier.sv
// -----------------------------------------------------------------------------
// tnn_stream_classifier
//
// Streaming ternary neural network classifier. Feature beats arrive one per
// transfer on a valid/ready input. Each beat updates every hidden neuron
// accumulator in parallel using a compile-time ternary weight (+1, -1, 0).
// After the last beat of a sample the block spends one cycle evaluating the
// hidden thresholds and the ternary output neuron. It then holds the 1-bit
// class and a sticky framing-error flag until the consumer takes the result.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   feature beat valid
//   in_ready   out  block accepts a beat (ACC state)
//   in_data    in   unsigned feature value, IN_W bits
//   in_last    in   sender end-of-sample marker; only checked, never framing
//   out_valid  out  result valid (HOLD state)
//   out_ready  in   consumer accepts result
//   out_class  out  predicted class
//   out_err    out  framing error seen in the reported sample
// -----------------------------------------------------------------------------
module tnn_stream_classifier #(
    parameter int                        N_FEAT = 6,
    parameter int                        IN_W   = 2,
    parameter int                        N_HID  = 4,
    parameter int                        TH_W   = 8,
    parameter logic [2*N_FEAT*N_HID-1:0] W_HID  = '0,
    parameter logic [N_HID*TH_W-1:0]     TH_HID = '0,
    parameter logic [2*N_HID-1:0]        W_OUT  = '0,
    parameter logic [TH_W-1:0]           TH_OUT = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_data,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_class,
    output logic            out_err
);

    localparam int CNT_W  = $clog2(N_FEAT);
    // Accumulator magnitude is at most N_FEAT*(2^IN_W-1); this width holds it.
    localparam int AW     = IN_W + $clog2(N_FEAT) + 2;
    // Common width for comparing an accumulator against its threshold.
    localparam int CW     = (AW > TH_W) ? AW : TH_W;
    // Output sum spans -N_HID..+N_HID; widen to hold TH_OUT as well.
    localparam int SW_MIN = $clog2(N_HID + 1) + 1;
    localparam int SW     = (SW_MIN > TH_W) ? SW_MIN : TH_W;

    typedef enum logic [1:0] {
        ST_ACC,
        ST_EVAL,
        ST_HOLD
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic signed [AW-1:0]  r_acc [N_HID];
    logic                  r_err;
    logic                  r_out_class;
    logic                  r_out_err;

    logic                  w_beat;
    logic                  w_res;
    logic                  w_is_last;
    logic                  w_frame_err;
    logic signed [AW-1:0]  w_feat;
    logic signed [AW-1:0]  w_acc_nxt [N_HID];
    logic signed [CW-1:0]  w_acc_ext;
    logic signed [CW-1:0]  w_th_ext;
    logic signed [SW-1:0]  w_sum;
    logic                  w_class;

    assign w_beat      = in_valid && (r_state == ST_ACC);
    assign w_res       = out_ready && (r_state == ST_HOLD);
    assign w_is_last   = (r_cnt == CNT_W'(N_FEAT - 1));
    // in_last must be set on exactly the final beat of the sample.
    assign w_frame_err = (in_last != w_is_last);
    assign w_feat      = $signed({{(AW - IN_W){1'b0}}, in_data});

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_ACC: begin
                in_ready = 1'b1;
                if (w_beat && w_is_last) w_state_nxt = ST_EVAL;
            end
            ST_EVAL: w_state_nxt = ST_HOLD;
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = ST_ACC;
            end
            default: w_state_nxt = ST_ACC;
        endcase
    end

    // Per-neuron accumulate: the weight is chosen by the current beat index.
    always_comb begin
        for (int j = 0; j < N_HID; j++) begin
            w_acc_nxt[j] = r_acc[j];
            for (int i = 0; i < N_FEAT; i++) begin
                if (r_cnt == CNT_W'(i)) begin
                    case (W_HID[2*(j*N_FEAT+i) +: 2])
                        2'b01:   w_acc_nxt[j] = r_acc[j] + w_feat;
                        2'b11:   w_acc_nxt[j] = r_acc[j] - w_feat;
                        default: w_acc_nxt[j] = r_acc[j];
                    endcase
                end
            end
        end
    end

    // Hidden activations and ternary output neuron, all signed.
    always_comb begin
        w_sum     = '0;
        w_acc_ext = '0;
        w_th_ext  = '0;
        for (int j = 0; j < N_HID; j++) begin
            w_acc_ext = CW'(r_acc[j]);
            w_th_ext  = CW'($signed(TH_HID[j*TH_W +: TH_W]));
            if (w_acc_ext >= w_th_ext) begin
                case (W_OUT[2*j +: 2])
                    2'b01:   w_sum = w_sum + SW'(1);
                    2'b11:   w_sum = w_sum - SW'(1);
                    default: w_sum = w_sum;
                endcase
            end
        end
        w_class = (w_sum >= SW'($signed(TH_OUT)));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ACC;
            r_cnt       <= '0;
            // NOTE: the accumulators are plain flops, not RAM, and must start
            // each sample at zero, so they are reset along with the control.
            for (int j = 0; j < N_HID; j++) r_acc[j] <= '0;
            r_err       <= 1'b0;
            r_out_class <= 1'b0;
            r_out_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_beat) begin
                r_cnt <= w_is_last ? '0 : r_cnt + CNT_W'(1);
                for (int j = 0; j < N_HID; j++) r_acc[j] <= w_acc_nxt[j];
                r_err <= r_err | w_frame_err;
            end
            if (r_state == ST_EVAL) begin
                r_out_class <= w_class;
                r_out_err   <= r_err;
            end
            // Result taken: start the next sample from a clean slate.
            if (w_res) begin
                for (int j = 0; j < N_HID; j++) r_acc[j] <= '0;
                r_err <= 1'b0;
            end
        end
    end

    assign out_class = r_out_class;
    assign out_err   = r_out_err;

endmodule

// File: tb/tb_tnn_stream_classifier.sv
// -----------------------------------------------------------------------------
// tb_tnn_stream_classifier
//
// Self-checking bench for tnn_stream_classifier with parameter set P1:
// N_FEAT=6, IN_W=2, N_HID=2; neuron0 all +1 with threshold 6, neuron1 all -1
// with threshold -3; output weights (+1,-1), output threshold 0.
// Directed samples use hand-computed results; the random phase uses a small
// behavioural model of P1.
// -----------------------------------------------------------------------------
module tb_tnn_stream_classifier;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic       out_class;
    logic       out_err;

    int n_checks = 0;
    int n_fail   = 0;

    tnn_stream_classifier #(
        .N_FEAT (6),
        .IN_W   (2),
        .N_HID  (2),
        .TH_W   (8),
        .W_HID  (24'hFFF555),
        .TH_HID (16'hFD06),
        .W_OUT  (4'hD),
        .TH_OUT (8'h00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // P1 reference: neuron0 sums features, neuron1 subtracts them.
    function automatic logic model_class(input logic [11:0] f);
        int a0 = 0;
        int a1 = 0;
        int s;
        for (int i = 0; i < 6; i++) begin
            a0 += int'(f[2*i +: 2]);
            a1 -= int'(f[2*i +: 2]);
        end
        s = ((a0 >= 6) ? 1 : 0) - ((a1 >= -3) ? 1 : 0);
        return (s >= 0);
    endfunction

    function automatic logic model_err(input logic [5:0] lastm);
        return (lastm != 6'b100000);
    endfunction

    // Send nbeats beats of f (beat i = f[2i+:2], in_last = lastm[i]) with up
    // to gap_max idle cycles before each. Returns 1ns after the last transfer.
    task automatic send_sample(input logic [11:0] f, input logic [5:0] lastm,
                               input int nbeats, input int gap_max);
        int t;
        for (int i = 0; i < nbeats; i++) begin
            repeat ((gap_max > 0) ? $urandom_range(0, gap_max) : 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = f[2*i +: 2];
            in_last  = lastm[i];
            t = 0;
            while (!in_ready && t < 50) begin
                @(posedge clk); #1;
                t++;
            end
            if (t >= 50) check("in_ready_wait", in_ready, 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    // Called 1ns after the last beat edge. Checks 2-cycle latency, holds the
    // result for 'stall' cycles while offering a stray beat, then takes it.
    task automatic get_result(input logic exp_c, input logic exp_e, input int stall);
        check("lat_eval_valid", out_valid, 0);
        check("lat_eval_ready", in_ready, 0);
        @(posedge clk); #1;
        check("lat_hold_valid", out_valid, 1);
        in_valid = 1'b1;
        in_data  = 2'd3;
        in_last  = 1'b1;
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            check("stall_valid", out_valid, 1);
            check("stall_class", out_class, exp_c);
            check("stall_ready", in_ready, 0);
        end
        check("class", out_class, exp_c);
        check("err", out_err, exp_e);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        check("res_valid_clr", out_valid, 0);
        check("res_ready_back", in_ready, 1);
    endtask

    initial begin
        logic [11:0] f;
        logic [5:0]  lastm;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_class", out_class, 0);
        check("rst_err", out_err, 0);
        check("rst_ready", in_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", in_ready, 1);
        check("post_rst_valid", out_valid, 0);

        // All ones: acc0=6>=6, acc1=-6<-3 -> s=+1 -> class 1.
        send_sample(12'h555, 6'b100000, 6, 0);
        get_result(1'b1, 1'b0, 0);
        // 1,0,0,0,0,0: acc0=1, acc1=-1>=-3 -> s=-1 -> class 0.
        send_sample(12'h001, 6'b100000, 6, 0);
        get_result(1'b0, 1'b0, 0);
        // 3,3,0,0,0,0: acc0=6, acc1=-6 -> class 1.
        send_sample(12'h00F, 6'b100000, 6, 0);
        get_result(1'b1, 1'b0, 0);

        // in_last on beat 2 only: result still after 6 beats, error flagged.
        send_sample(12'h555, 6'b000100, 6, 0);
        get_result(1'b1, 1'b1, 0);
        send_sample(12'h001, 6'b100000, 6, 0);
        get_result(1'b0, 1'b0, 0);

        // Hold result 10 cycles with a stray beat offered; the next sample
        // must come out clean if none of the stray beats were consumed.
        send_sample(12'h555, 6'b100000, 6, 0);
        get_result(1'b1, 1'b0, 10);
        @(posedge clk); #1;
        check("single_xfer", out_valid, 0);
        send_sample(12'h001, 6'b100000, 6, 0);
        get_result(1'b0, 1'b0, 0);

        // Reset after 3 beats (3,3,3), then an all-ones sample.
        send_sample(12'h03F, 6'b000000, 3, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_valid", out_valid, 0);
        @(posedge clk); #1;
        check("abort_no_result", out_valid, 0);
        check("abort_ready", in_ready, 1);
        send_sample(12'h555, 6'b100000, 6, 0);
        get_result(1'b1, 1'b0, 0);
        // Same abort, then 1,0,...: stale accumulators would give class 1.
        send_sample(12'h03F, 6'b000000, 3, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send_sample(12'h001, 6'b100000, 6, 0);
        get_result(1'b0, 1'b0, 0);

        // Random features, framing and back-pressure against the model.
        for (int s = 0; s < 1000; s++) begin
            f     = 12'($urandom);
            lastm = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'b100000;
            send_sample(f, lastm, 6, 2);
            get_result(model_class(f), model_err(lastm), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tnn_stream_classifier.md
TNN_STREAM_CLASSIFIER -- requirements
Module: tnn_stream_classifier

Interface
REQ-001 SHALL have parameter N_FEAT, default 6: feature beats per sample (>=2).
REQ-002 SHALL have parameter IN_W, default 2: unsigned feature width.
REQ-003 SHALL have parameter N_HID, default 4: hidden neurons (>=1).
REQ-004 SHALL have parameter TH_W, default 8: signed threshold width.
REQ-005 SHALL have parameter W_HID, default 0, width 2*N_FEAT*N_HID: hidden ternary weights; field [2*(j*N_FEAT+i)+:2] is the weight of feature i into neuron j; 01=+1, 11=-1, 00/10=0.
REQ-006 SHALL have parameter TH_HID, default 0, width N_HID*TH_W: signed hidden thresholds; field j belongs to neuron j.
REQ-007 SHALL have parameter W_OUT, default 0, width 2*N_HID: output ternary weights, same encoding as W_HID.
REQ-008 SHALL have parameter TH_OUT, default 0, width TH_W: signed output threshold.
REQ-009 SHALL have port clk, input, 1: the only clock; all logic is rising-edge.
REQ-010 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-011 SHALL have port in_valid, input, 1: feature beat valid.
REQ-012 SHALL have port in_ready, output, 1: block can accept a beat.
REQ-013 SHALL have port in_data, input, IN_W: unsigned feature value.
REQ-014 SHALL have port in_last, input, 1: sender's end-of-sample marker; checked only, never used for framing.
REQ-015 SHALL have port out_valid, output, 1: result valid.
REQ-016 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-017 SHALL have port out_class, output, 1: predicted class.
REQ-018 SHALL have port out_err, output, 1: framing error seen in this sample.

Function
REQ-019 SHALL transfer a beat only on a rising edge with in_valid=1 and in_ready=1, and a result only on a rising edge with out_valid=1 and out_ready=1.
REQ-020 SHALL implement states ACC (in_ready=1, out_valid=0), EVAL (both 0) and HOLD (in_ready=0, out_valid=1).
REQ-021 SHALL keep a beat counter 0..N_FEAT-1; feature index i is the counter value when the beat transfers.
REQ-022 SHALL, in ACC on each transfer, update every hidden accumulator in parallel: acc_j += in_data, -= in_data or unchanged, per the weight for (j,i); arithmetic is signed, width IN_W+clog2(N_FEAT)+2, and SHALL never overflow.
REQ-023 SHALL, on the transfer with counter=N_FEAT-1, wrap the counter to 0 and go to EVAL.
REQ-024 SHALL, in EVAL (exactly one cycle), compute h_j = (acc_j >= sign-extended TH_HID_j), then s = sum of w_out_j*h_j, then register out_class = (s >= TH_OUT) signed, and go to HOLD.
REQ-025 SHALL, with the last beat transferred at edge k, assert out_valid from the cycle after edge k+1; latency is 2 cycles.
REQ-026 SHALL hold out_class and out_err stable in HOLD until the result transfers; on that edge clear all accumulators and the error flag and return to ACC.
REQ-027 SHALL set the sticky error flag when in_last=1 transfers with counter != N_FEAT-1, or in_last=0 transfers with counter = N_FEAT-1; out_err shows the flag for the sample being reported.
REQ-028 SHALL ignore in_valid, in_data and in_last outside ACC; SHALL NOT accept a new sample's beats before the previous result transfers.
REQ-029 SHALL ignore out_ready outside HOLD.

Reset
REQ-030 SHALL, while rst=1 at an edge, force state ACC, counter 0, accumulators 0, error flag 0, out_valid=0, out_class=0, out_err=0; in_ready SHALL be 1 from the cycle after reset.
REQ-031 SHALL let rst override any state mid-sample or in HOLD; a partial sample SHALL be discarded with no result.

Verification
Bench parameter set P1: N_FEAT=6, IN_W=2, N_HID=2, neuron0 all +1 with TH=6, neuron1 all -1 with TH=-3, W_OUT=(+1,-1), TH_OUT=0.
REQ-032 SHALL pass: P1, features 1,1,1,1,1,1 with in_last on beat 5 -> out_class=1, out_err=0, out_valid 2 cycles after the last beat.
REQ-033 SHALL pass: P1, features 1,0,0,0,0,0 -> out_class=0, out_err=0; features 3,3,0,0,0,0 -> out_class=1.
REQ-034 SHALL pass: P1, in_last on beat 2 and not on beat 5 -> result after 6 beats, out_err=1; the next clean sample -> out_err=0.
REQ-035 SHALL pass: out_ready held 0 for 10 cycles in HOLD -> out_valid and out_class stable, in_ready=0, offered beats not consumed; on release the result transfers once and in_ready=1 the next cycle.
REQ-036 SHALL pass: rst pulsed after 3 beats, then a full all-ones sample -> out_class=1 and no spurious result for the aborted sample.
REQ-037 SHALL pass: random in_valid/out_ready back-pressure over 1000 samples -> every result matches a reference model.
